// File: rtl/bin_to_bcd_pkg.sv
// ============================================================================
// Module   : bin_to_bcd_pkg
// Purpose  : Shared types and helpers for the binary-fraction to BCD converter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bin_to_bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // The digit counter must be able to hold the digit count itself.
  function automatic int cnt_width(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin_to_bcd_frac_mul10.sv
// ============================================================================
// Module   : frac_mul10
// Purpose  : Multiplies a Q0.F fraction by ten and splits off the integer digit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frac_mul10
  import bin_to_bcd_pkg::*;
#(
  parameter int F = 8
) (
  input  logic [F-1:0]             frac_i,
  output logic [BCD_DIGIT_W-1:0]   digit_o,
  output logic [F-1:0]             rem_o
);

  logic [F+3:0] frac_ext;
  logic [F+3:0] prod;

  assign frac_ext = {4'b0000, frac_i};
  // frac < 1, so frac*10 < 10 and the upper nibble is always a valid BCD digit.
  assign prod     = (frac_ext << 3) + (frac_ext << 1);
  assign digit_o  = prod[F+3:F];
  assign rem_o    = prod[F-1:0];

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_frac.sv
// ============================================================================
// Module   : bin_to_bcd_frac
// Purpose  : Sequential Q0.F fraction to D-digit BCD converter, one digit/clock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_frac
  import bin_to_bcd_pkg::*;
#(
  parameter int FRACTIONAL_BITS = 8,
  parameter int DECIMAL_DIGITS  = 7
) (
  input  logic                                    i_Clock,
  input  logic                                    i_Rst_L,
  input  logic                                    i_Start,
  input  logic [FRACTIONAL_BITS-1:0]              i_Binary,
  output logic [BCD_DIGIT_W*DECIMAL_DIGITS-1:0]   o_BCD,
  output logic                                    o_DV
);

  localparam int F  = FRACTIONAL_BITS;
  localparam int D  = DECIMAL_DIGITS;
  localparam int DW = BCD_DIGIT_W * D;
  localparam int CW = cnt_width(D);
  localparam logic [CW-1:0] LAST_CNT = CW'(D - 1);

  state_e               state_q, state_d;
  logic [F-1:0]         frac_q, frac_d;
  logic [DW-1:0]        digits_q, digits_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        bcd_q, bcd_d;
  logic                 dv_q, dv_d;

  logic [BCD_DIGIT_W-1:0] digit;
  logic [F-1:0]           rem;
  logic [DW-1:0]          digits_shift;

  frac_mul10 #(.F(F)) u_mul10 (
    .frac_i  (frac_q),
    .digit_o (digit),
    .rem_o   (rem)
  );

  generate
    if (D == 1) begin : g_single_digit
      assign digits_shift = digit;
    end else begin : g_multi_digit
      assign digits_shift = {digits_q[DW-BCD_DIGIT_W-1:0], digit};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    frac_d   = frac_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    dv_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Start) begin
          state_d  = CONVERT;
          frac_d   = i_Binary;
          digits_d = '0;
          cnt_d    = '0;
        end
      end
      CONVERT: begin
        frac_d   = rem;
        digits_d = digits_shift;
        cnt_d    = cnt_q + CW'(1);
        // The last digit goes straight into the output so o_BCD never shows partial results.
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          bcd_d   = digits_shift;
          dv_d    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      frac_q   <= '0;
      digits_q <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      frac_q   <= frac_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      dv_q     <= dv_d;
    end
  end

  assign o_BCD = bcd_q;
  assign o_DV  = dv_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_frac.sv
// ============================================================================
// Module   : tb_bin_to_bcd_frac
// Purpose  : Self-checking bench for bin_to_bcd_frac (F=8, D=7).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_frac;

  localparam int F  = 8;
  localparam int D  = 7;
  localparam int DW = 4 * D;

  logic          i_Clock = 1'b0;
  logic          i_Rst_L = 1'b0;
  logic          i_Start = 1'b0;
  logic [F-1:0]  i_Binary = '0;
  logic [DW-1:0] o_BCD;
  logic          o_DV;

  int n_checks = 0;
  int n_pass   = 0;

  bin_to_bcd_frac #(
    .FRACTIONAL_BITS (F),
    .DECIMAL_DIGITS  (D)
  ) dut (
    .i_Clock  (i_Clock),
    .i_Rst_L  (i_Rst_L),
    .i_Start  (i_Start),
    .i_Binary (i_Binary),
    .o_BCD    (o_BCD),
    .o_DV     (o_DV)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Truncated decimal expansion: floor(b * 10^D / 2^F), written out as D BCD digits.
  function automatic logic [DW-1:0] ref_bcd(input logic [F-1:0] b);
    longint unsigned p10 = 1;
    longint unsigned q;
    logic [DW-1:0] r = '0;
    for (int i = 0; i < D; i++) p10 = p10 * 10;
    q = (longint'(b) * p10) / (longint'(1) << F);
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(q % 10);
      q = q / 10;
    end
    return r;
  endfunction

  // Start one conversion, optionally re-pulse start mid-way, then verify latency/result/pulse width.
  task automatic run_conv(input string tag, input logic [F-1:0] b, input logic [DW-1:0] exp,
                          input bit disturb);
    int lat;
    @(negedge i_Clock);
    i_Start  = 1'b1;
    i_Binary = b;
    @(posedge i_Clock); #1;
    i_Start  = 1'b0;
    i_Binary = F'($urandom);
    lat = 0;
    while (!o_DV && lat < 20) begin
      if (disturb && lat == 3) begin
        @(negedge i_Clock);
        i_Start  = 1'b1;
        i_Binary = ~b;
        @(posedge i_Clock); #1;
        i_Start  = 1'b0;
      end else begin
        @(posedge i_Clock); #1;
      end
      lat++;
    end
    check_eq({tag, "_latency"}, lat, D);
    check_eq({tag, "_bcd"}, o_BCD, exp);
    @(posedge i_Clock); #1;
    check_eq({tag, "_dv_one_cycle"}, o_DV, 0);
  endtask

  initial begin
    logic [F-1:0] b;
    int cyc, npulse, extra;
    int pulse_at[3];

    repeat (3) @(posedge i_Clock);
    #1;
    check_eq("reset_bcd", o_BCD, 0);
    check_eq("reset_dv", o_DV, 0);
    @(negedge i_Clock);
    i_Rst_L = 1'b1;

    run_conv("a0", 8'hA0, 28'h6250000, 0);
    run_conv("80", 8'h80, 28'h5000000, 0);
    run_conv("60", 8'h60, 28'h3750000, 0);
    run_conv("1a", 8'h1A, 28'h1015625, 0);
    run_conv("00", 8'h00, 28'h0000000, 0);
    run_conv("ff", 8'hFF, 28'h9960937, 0);
    run_conv("restart_ignored", 8'h60, 28'h3750000, 1);

    // Reset after three digits: no pulse, output cleared, then a clean conversion.
    @(negedge i_Clock);
    i_Start  = 1'b1;
    i_Binary = 8'h1A;
    @(posedge i_Clock); #1;
    i_Start = 1'b0;
    repeat (3) @(posedge i_Clock);
    @(negedge i_Clock);
    i_Rst_L = 1'b0;
    #1;
    check_eq("midreset_dv", o_DV, 0);
    check_eq("midreset_bcd", o_BCD, 0);
    @(negedge i_Clock);
    i_Rst_L = 1'b1;
    extra = 0;
    repeat (12) begin
      @(posedge i_Clock); #1;
      if (o_DV) extra++;
    end
    check_eq("midreset_no_dv", extra, 0);
    check_eq("midreset_idle_bcd", o_BCD, 0);
    run_conv("after_reset", 8'hA0, 28'h6250000, 0);

    // Start held high: back-to-back conversions every D+2 clocks.
    @(negedge i_Clock);
    i_Start  = 1'b1;
    i_Binary = 8'h1A;
    @(posedge i_Clock); #1;
    cyc = 0;
    npulse = 0;
    while (npulse < 3 && cyc < 60) begin
      @(posedge i_Clock); #1;
      cyc++;
      if (npulse > 0) check_eq("hold_bcd_stable", o_BCD, 28'h1015625);
      if (o_DV) begin
        pulse_at[npulse] = cyc;
        npulse++;
        check_eq("hold_bcd", o_BCD, 28'h1015625);
      end
    end
    i_Start = 1'b0;
    check_eq("hold_pulse_count", npulse, 3);
    if (npulse == 3) begin
      check_eq("hold_first_latency", pulse_at[0], D);
      check_eq("hold_period_1", pulse_at[1] - pulse_at[0], D + 2);
      check_eq("hold_period_2", pulse_at[2] - pulse_at[1], D + 2);
    end
    extra = 0;
    repeat (15) begin
      @(posedge i_Clock); #1;
      if (o_DV) extra++;
    end
    check_eq("drop_start_no_retrigger", extra, 0);

    // Randomized values against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      b = F'($urandom);
      run_conv("rand", b, ref_bcd(b), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin_to_bcd_frac.md
# bin_to_bcd_frac

Sequential converter from an unsigned binary fraction (Q0.F, value = i_Binary / 2^F) to a fixed number of BCD digits after the decimal point. It uses repeated multiply-by-ten and produces one digit per clock. It sits in the calculator display path beside the integer binary-to-BCD converter, and formats the fractional part of fixed-point results such as Q16.8.

## Interface

Parameters:
- FRACTIONAL_BITS, default 8: width F of the binary fraction input.
- DECIMAL_DIGITS, default 7: number D of decimal digits produced, D ≥ 1.

Ports:
- i_Clock  in  1  sole clock; all state updates on the rising edge.
- i_Rst_L  in  1  reset, asynchronous and active-low.
- i_Start  in  1  start request; level-sampled only in IDLE.
- i_Binary  in  F  fraction bits; value = i_Binary / 2^F; captured on the start edge.
- o_BCD  out  4*D  result digits; o_BCD[4*D-1 -: 4] is the first digit after the point (tenths), o_BCD[3:0] is the last.
- o_DV  out  1  one-cycle pulse marking a new valid o_BCD.

## Operation

- States:
  - IDLE: waits for i_Start.
  - CONVERT: generates one digit per clock.
  - DONE: one cycle, o_DV high.
- IDLE → CONVERT: on a rising edge with i_Start=1.
  - Load the fraction register r_Frac (F bits) with i_Binary.
  - Clear the digit shift register r_Digits (4*D bits).
  - Clear the digit counter.
- CONVERT, each edge:
  - Product p = r_Frac*10, computed as (r_Frac<<3)+(r_Frac<<1), F+4 bits wide.
  - Digit = p[F+3:F]. It is always 0..9, so no correction is needed.
  - r_Frac ← p[F-1:0].
  - r_Digits ← {r_Digits[4*D-5:0], digit}; the first digit ends up in the MS nibble.
  - Counter increments.
  - After the D-th digit, go to DONE.
- DONE:
  - o_BCD ← final digit vector (shift register plus the D-th digit, loaded on the same edge as entry).
  - o_DV = 1.
  - Next edge returns to IDLE.
- Arithmetic:
  - Results are truncated, never rounded.
  - The result is exact whenever the fraction terminates within D digits. For example, 26/256 = 0.1015625 gives digits 1,0,1,5,6,2,5.
- Early zero: a zero remainder keeps producing 0 digits. There is no early exit, so latency is constant.
- o_BCD holds its last result until the next conversion completes. Intermediate digits are never visible on o_BCD.
- i_Binary and i_Start are ignored outside IDLE. A new request during CONVERT or DONE is dropped.
- If i_Start is still high when IDLE is re-entered, a new conversion starts on that edge.
- Reset: asynchronous when i_Rst_L=0.
  - State goes to IDLE; o_BCD, o_DV, r_Frac, r_Digits and the counter all go to 0.
  - Reset mid-conversion aborts it without any o_DV pulse.

## Timing

- Edge 0: i_Start=1 is sampled in IDLE; i_Binary is captured.
- Edges 1..D: one digit each.
- After edge D, o_DV=1 and o_BCD is valid, for exactly one cycle.
- Edge D+1: back in IDLE, o_DV=0.
- Start-to-DV latency is D clocks. Throughput is one conversion per D+2 clocks when i_Start is held high.
- o_DV and o_BCD are registered outputs with no combinational path from the inputs.
- The requester may drop i_Start on seeing o_DV; that gives no re-trigger.

## Structure

- Shared package bin_to_bcd_pkg:
  - state enum {IDLE, CONVERT, DONE}.
  - BCD_DIGIT_W = 4.
  - Counter width function clog2(D+1).
- Optional sub-module frac_mul10 (combinational, parameter F): input r_Frac; outputs the digit (4 bits) and the remainder (F bits).
- The top level holds the FSM, r_Frac, r_Digits, the counter and the output registers.

## Test plan

- F=8, D=7, i_Binary=8'hA0 (0.625), i_Start held until o_DV → o_BCD=28'h6250000, o_DV high for 1 cycle, 7 clocks after the start edge.
- i_Binary=8'h80 → 28'h5000000; i_Binary=8'h60 → 28'h3750000; i_Binary=8'h1A → 28'h1015625.
- i_Binary=8'h00 → 28'h0000000. i_Binary=8'hFF → 28'h9960937 (truncated from 0.99609375).
- i_Start pulsed high again mid-conversion with a new i_Binary → ignored; the original result is delivered on schedule.
- i_Rst_L pulsed low at digit 3 → o_DV stays 0; o_BCD=0 and the FSM is in IDLE. The next start converts normally.
- i_Start held high continuously → o_DV pulses every D+2=9 clocks with identical o_BCD; o_BCD is stable between pulses.
